// File: rtl/vga_frame_scheduler.sv
// vga_frame_scheduler
// Arbitrates the single-port tile memory between the VGA renderer (reads,
// active video) and the snake game logic (buffered writes, committed only
// in blanking). Also derives the game-step tick from frame starts and
// tracks the step handshake with the game logic, flagging overruns.
//
// Optional build macro: VGA_SCHED_STATS_EN adds the wr_count output, the
// number of writes committed during the previous frame (saturating at 255).
//
// Step FSM:
//   state    | meaning
//   S_IDLE   | no game step outstanding; waiting for a due tick
//   S_UPDATE | tick issued; waiting for update_done from the game logic

module vga_frame_scheduler #(
    parameter int ADDR_W      = 10,
    parameter int DATA_W      = 3,
    parameter int TICK_FRAMES = 8
) (
    input  logic              clock_25,
    input  logic              reset,
    input  logic              display_area,
    input  logic              frame_tik,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic              run,
    input  logic              wr_valid,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ready,
    input  logic              update_done,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              game_tick,
    output logic              busy,
`ifdef VGA_SCHED_STATS_EN
    output logic [7:0]        wr_count,
`endif
    output logic              overrun
);

    // Frame counter terminal value: the wrap from here to 0 makes a tick due.
    localparam logic [7:0] TICK_LAST = 8'(TICK_FRAMES - 1);

    typedef enum logic {
        S_IDLE   = 1'b0,
        S_UPDATE = 1'b1
    } state_t;

    // Single-entry write buffer.
    logic              pend_full_q;
    logic              pend_full_d;
    logic [ADDR_W-1:0] pend_addr_q;
    logic [DATA_W-1:0] pend_data_q;
    logic              wr_accept;
    logic              commit;

    // Registered memory port.
    logic [ADDR_W-1:0] mem_addr_q;
    logic              mem_we_q;
    logic [DATA_W-1:0] mem_wdata_q;

    // Frame start detection and frames-per-step counter.
    logic              frame_tik_q;
    logic              frame_start;
    logic [7:0]        frame_cnt_q;
    logic [7:0]        frame_cnt_d;
    logic              tick_due;

    // Step FSM with registered outputs.
    state_t            state_q;
    logic              game_tick_q;
    logic              busy_q;
    logic              overrun_q;

    // wr_ready comes straight from the buffer flag, so the game side never
    // sees a combinational path from its own wr_valid.
    assign wr_ready    = ~pend_full_q;
    assign wr_accept   = wr_valid & ~pend_full_q;

    // The renderer always wins during active video; a pending write drains
    // on the first blanking cycle.
    assign commit      = ~display_area & pend_full_q;

    // An accept can only happen with the buffer empty, so it never races a
    // commit of the same entry.
    assign pend_full_d = wr_accept | (pend_full_q & ~commit);

    assign frame_start = frame_tik & ~frame_tik_q;

    assign mem_addr    = mem_addr_q;
    assign mem_we      = mem_we_q;
    assign mem_wdata   = mem_wdata_q;
    assign game_tick   = game_tick_q;
    assign busy        = busy_q;
    assign overrun     = overrun_q;

    // Write buffer capture and drain bookkeeping.
    always_ff @(posedge clock_25 or negedge reset) begin
        if (!reset) begin
            pend_full_q <= 1'b0;
            pend_addr_q <= '0;
            pend_data_q <= '0;
        end else begin
            pend_full_q <= pend_full_d;
            if (wr_accept) begin
                pend_addr_q <= wr_addr;
                pend_data_q <= wr_data;
            end
        end
    end

    // Registered port mux: renderer address unless a blanking commit is due.
    // mem_wdata is only loaded on a commit so it holds between writes.
    always_ff @(posedge clock_25 or negedge reset) begin
        if (!reset) begin
            mem_addr_q  <= '0;
            mem_we_q    <= 1'b0;
            mem_wdata_q <= '0;
        end else if (commit) begin
            mem_addr_q  <= pend_addr_q;
            mem_wdata_q <= pend_data_q;
            mem_we_q    <= 1'b1;
        end else begin
            mem_addr_q  <= rd_addr;
            mem_we_q    <= 1'b0;
        end
    end

    // Next frame count; the wrap from TICK_LAST flags a due tick.
    always_comb begin
        frame_cnt_d = frame_cnt_q;
        tick_due    = 1'b0;
        if (!run) begin
            frame_cnt_d = '0;
        end else if (frame_start) begin
            if (frame_cnt_q == TICK_LAST) begin
                frame_cnt_d = '0;
                tick_due    = 1'b1;
            end else begin
                frame_cnt_d = frame_cnt_q + 8'd1;
            end
        end
    end

    // frame_tik edge register and frame counter; the counter keeps advancing
    // during an outstanding step, which is what drops a late tick.
    always_ff @(posedge clock_25 or negedge reset) begin
        if (!reset) begin
            frame_tik_q <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            frame_tik_q <= frame_tik;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    // Step FSM: issues game_tick, tracks busy, latches sticky overrun.
    // game_tick can only fire from S_IDLE and always moves to S_UPDATE, so it
    // is never high on two consecutive cycles.
    always_ff @(posedge clock_25 or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            game_tick_q <= 1'b0;
            busy_q      <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            game_tick_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (tick_due) begin
                        game_tick_q <= 1'b1;
                        busy_q      <= 1'b1;
                        state_q     <= S_UPDATE;
                    end
                end
                S_UPDATE: begin
                    // A finish arriving in the same cycle as a frame start
                    // still counts as in time.
                    if (update_done) begin
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end else if (frame_start) begin
                        overrun_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

`ifdef VGA_SCHED_STATS_EN
    logic [7:0] wr_acc_q;
    logic [7:0] wr_count_q;

    assign wr_count = wr_count_q;

    // Per-frame commit counter; a commit landing on the frame start opens
    // the new window with a count of one.
    always_ff @(posedge clock_25 or negedge reset) begin
        if (!reset) begin
            wr_acc_q   <= '0;
            wr_count_q <= '0;
        end else if (frame_start) begin
            wr_count_q <= wr_acc_q;
            wr_acc_q   <= {7'd0, mem_we_q};
        end else if (mem_we_q && (wr_acc_q != 8'hFF)) begin
            wr_acc_q   <= wr_acc_q + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_vga_frame_scheduler.sv
// Testbench for vga_frame_scheduler. A transaction-level model (write queue,
// frames-since-run count, step handshake flags) predicts every output each
// cycle; scenario tasks add directed checks on top.
module tb_vga_frame_scheduler;

    localparam int AW   = 10;
    localparam int DW   = 3;
    localparam int TICK = 3;
    localparam int ACT  = 20;   // active-video cycles per frame
    localparam int FR   = 32;   // cycles per frame
    localparam int TS   = 22;   // first frame_tik cycle in a frame
    localparam int VW   = AW + DW + 5;

    logic          clock_25 = 1'b0;
    logic          reset = 1'b0;
    logic          display_area = 1'b0;
    logic          frame_tik = 1'b0;
    logic [AW-1:0] rd_addr = '0;
    logic          run = 1'b0;
    logic          wr_valid = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [DW-1:0] wr_data = '0;
    logic          update_done = 1'b0;
    logic          wr_ready;
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [DW-1:0] mem_wdata;
    logic          game_tick;
    logic          busy;
    logic          overrun;
`ifdef VGA_SCHED_STATS_EN
    logic [7:0]    wr_count;
`endif

    vga_frame_scheduler #(
        .ADDR_W      (AW),
        .DATA_W      (DW),
        .TICK_FRAMES (TICK)
    ) dut (
        .clock_25     (clock_25),
        .reset        (reset),
        .display_area (display_area),
        .frame_tik    (frame_tik),
        .rd_addr      (rd_addr),
        .run          (run),
        .wr_valid     (wr_valid),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .wr_ready     (wr_ready),
        .update_done  (update_done),
        .mem_addr     (mem_addr),
        .mem_we       (mem_we),
        .mem_wdata    (mem_wdata),
        .game_tick    (game_tick),
        .busy         (busy),
`ifdef VGA_SCHED_STATS_EN
        .wr_count     (wr_count),
`endif
        .overrun      (overrun)
    );

    always #20 clock_25 = ~clock_25;

    int vectors = 0;
    int miscompares = 0;

    // Reference model state.
    logic [AW+DW-1:0] pend_q[$];
    logic [AW-1:0]    m_addr;
    logic             m_we;
    logic [DW-1:0]    m_wdata;
    logic             m_tik_prev;
    int               m_frames;
    logic             m_busy;
    logic             m_overrun;
    logic             m_tick;

    // Stimulus control.
    int fs_count;
    int done_cnt;
    int done_delay;
    int phase;
    bit auto_frames;
    bit force_fs_done;
    bit inject_done;

    localparam logic [VW-1:0] RST_VEC = {{AW{1'b0}}, 1'b0, {DW{1'b0}}, 1'b1, 1'b0, 1'b0, 1'b0};

    logic [VW-1:0] dut_vec;
    assign dut_vec = {mem_addr, mem_we, mem_wdata, wr_ready, game_tick, busy, overrun};

    function automatic logic [VW-1:0] exp_vec();
        logic rdy;
        rdy = (pend_q.size() == 0) ? 1'b1 : 1'b0;
        return {m_addr, m_we, m_wdata, rdy, m_tick, m_busy, m_overrun};
    endfunction

    task automatic model_clear();
        pend_q.delete();
        m_addr = '0; m_we = 1'b0; m_wdata = '0; m_tik_prev = 1'b0;
        m_frames = 0; m_busy = 1'b0; m_overrun = 1'b0; m_tick = 1'b0;
        fs_count = 0; done_cnt = 0; done_delay = 0; phase = 0;
        auto_frames = 1'b0; force_fs_done = 1'b0; inject_done = 1'b0;
    endtask

    // Advance model and DUT by one clock using the inputs currently driven.
    task automatic step();
        logic fs, acc, due, n_we, n_tick, n_busy, n_ovr;
        logic [AW-1:0] n_addr;
        logic [DW-1:0] n_wdata;
        logic [AW+DW-1:0] e;
        fs  = frame_tik && !m_tik_prev;
        acc = wr_valid && (pend_q.size() == 0);
        n_addr = rd_addr; n_we = 1'b0; n_wdata = m_wdata;
        if (!display_area && pend_q.size() > 0) begin
            e = pend_q.pop_front();
            n_addr = e[AW+DW-1:DW]; n_wdata = e[DW-1:0]; n_we = 1'b1;
        end
        if (acc) pend_q.push_back({wr_addr, wr_data});
        due = 1'b0;
        if (!run) m_frames = 0;
        else if (fs) begin
            m_frames++;
            fs_count++;
            if (m_frames == TICK) begin m_frames = 0; due = 1'b1; end
        end
        n_tick = 1'b0; n_busy = m_busy; n_ovr = m_overrun;
        if (!m_busy) begin
            if (due) begin n_tick = 1'b1; n_busy = 1'b1; end
        end else if (update_done) n_busy = 1'b0;
        else if (fs) n_ovr = 1'b1;
        @(posedge clock_25);
        m_addr = n_addr; m_we = n_we; m_wdata = n_wdata;
        m_tick = n_tick; m_busy = n_busy; m_overrun = n_ovr;
        m_tik_prev = frame_tik;
        #1;
    endtask

    // One cycle of frame timing plus the game-side update_done responder.
    task automatic cycle();
        if (auto_frames) begin
            display_area = (phase < ACT);
            frame_tik    = (phase >= TS) && (phase < TS + 3);
        end
        update_done = 1'b0;
        if (done_cnt > 0) begin
            done_cnt--;
            if (done_cnt == 0) update_done = 1'b1;
        end
        if (force_fs_done && frame_tik && !m_tik_prev) begin
            update_done = 1'b1;
            force_fs_done = 1'b0;
        end
        if (inject_done) update_done = 1'b1;
        step();
        if (m_tick && done_delay > 0) done_cnt = done_delay;
        phase = (phase + 1) % FR;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        display_area = 1'b0; frame_tik = 1'b0; run = 1'b0; wr_valid = 1'b0;
        update_done = 1'b0; rd_addr = '0; wr_addr = '0; wr_data = '0;
        model_clear();
        repeat (2) @(posedge clock_25);
        @(negedge clock_25);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        model_clear();
        #5;
        vectors++;
        if (dut_vec !== RST_VEC) begin
            miscompares++;
            $display("FAIL reset_async got=%h exp=%h", dut_vec, RST_VEC);
        end
        display_area = 1'b0; wr_valid = 1'b1; wr_addr = 10'h155; rd_addr = 10'h0AA;
        @(posedge clock_25); #1;
        vectors++;
        if (dut_vec !== RST_VEC) begin
            miscompares++;
            $display("FAIL reset_held got=%h exp=%h", dut_vec, RST_VEC);
        end
        do_reset();
        for (int i = 0; i < 4; i++) begin
            cycle();
            vectors++;
            if (dut_vec !== exp_vec()) begin
                miscompares++;
                $display("FAIL reset_release cyc=%0d got=%h exp=%h", i, dut_vec, exp_vec());
            end
        end
    endtask

    task automatic test_write_active();
        do_reset();
        rd_addr = 10'h1C3; display_area = 1'b1;
        wr_valid = 1'b1; wr_addr = 10'h005; wr_data = 3'd3;
        cycle();
        wr_valid = 1'b0;
        vectors++;
        if (wr_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL active_wr_ready got=%b exp=0", wr_ready);
        end
        for (int i = 0; i < 4; i++) begin
            cycle();
            vectors++;
            if (mem_we !== 1'b0 || dut_vec !== exp_vec()) begin
                miscompares++;
                $display("FAIL active_hold cyc=%0d got=%h exp=%h", i, dut_vec, exp_vec());
            end
        end
        display_area = 1'b0;
        cycle();
        vectors++;
        if ({mem_we, mem_addr, mem_wdata, wr_ready} !== {1'b1, 10'h005, 3'd3, 1'b1}) begin
            miscompares++;
            $display("FAIL active_commit got we=%b addr=%h data=%0d rdy=%b exp we=1 addr=005 data=3 rdy=1",
                     mem_we, mem_addr, mem_wdata, wr_ready);
        end
        cycle();
        vectors++;
        if (mem_we !== 1'b0 || dut_vec !== exp_vec()) begin
            miscompares++;
            $display("FAIL active_after got=%h exp=%h", dut_vec, exp_vec());
        end
    endtask

    task automatic test_back_to_back();
        logic [AW-1:0] addrs [4];
        logic [DW-1:0] datas [4];
        int k, ncommit, last_cyc;
        bit will_acc;
        addrs[0] = 10'h010; addrs[1] = 10'h221; addrs[2] = 10'h332; addrs[3] = 10'h3FF;
        datas[0] = 3'd1; datas[1] = 3'd6; datas[2] = 3'd2; datas[3] = 3'd7;
        do_reset();
        display_area = 1'b0;
        k = 0; ncommit = 0; last_cyc = -2;
        for (int i = 0; i < 12; i++) begin
            rd_addr = AW'($urandom);
            wr_valid = (k < 4);
            if (k < 4) begin wr_addr = addrs[k]; wr_data = datas[k]; end
            will_acc = wr_valid && (pend_q.size() == 0);
            cycle();
            if (will_acc) k++;
            vectors++;
            if (dut_vec !== exp_vec()) begin
                miscompares++;
                $display("FAIL b2b cyc=%0d got=%h exp=%h", i, dut_vec, exp_vec());
            end
            if (mem_we === 1'b1) begin
                vectors++;
                if (ncommit > 3 || mem_addr !== addrs[ncommit] || mem_wdata !== datas[ncommit]
                    || (ncommit > 0 && i - last_cyc != 2)) begin
                    miscompares++;
                    $display("FAIL b2b_commit n=%0d got addr=%h data=%0d gap=%0d exp gap=2",
                             ncommit, mem_addr, mem_wdata, i - last_cyc);
                end
                ncommit++;
                last_cyc = i;
            end
        end
        wr_valid = 1'b0;
        vectors++;
        if (ncommit !== 4) begin
            miscompares++;
            $display("FAIL b2b_count got=%0d exp=4", ncommit);
        end
    endtask

    task automatic test_tick();
        int nticks;
        do_reset();
        auto_frames = 1'b1; run = 1'b1; done_delay = 10; nticks = 0;
        for (int i = 0; i < 9 * FR + 4; i++) begin
            rd_addr = AW'($urandom);
            cycle();
            vectors++;
            if (dut_vec !== exp_vec()) begin
                miscompares++;
                $display("FAIL tick cyc=%0d got=%h exp=%h", i, dut_vec, exp_vec());
            end
            if (game_tick === 1'b1) begin
                nticks++;
                vectors++;
                if (fs_count !== TICK * nticks) begin
                    miscompares++;
                    $display("FAIL tick_frame got=%0d exp=%0d", fs_count, TICK * nticks);
                end
            end
        end
        vectors++;
        if (nticks !== 3 || overrun !== 1'b0) begin
            miscompares++;
            $display("FAIL tick_total got ticks=%0d ovr=%b exp ticks=3 ovr=0", nticks, overrun);
        end
    endtask

    task automatic wait_tick(input string name, input int budget);
        for (int i = 0; i < budget && !m_tick; i++) begin
            cycle();
            vectors++;
            if (dut_vec !== exp_vec()) begin
                miscompares++;
                $display("FAIL %s_wait got=%h exp=%h", name, dut_vec, exp_vec());
            end
        end
        vectors++;
        if (game_tick !== 1'b1) begin
            miscompares++;
            $display("FAIL %s_tick got=%b exp=1", name, game_tick);
        end
    endtask

    task automatic test_overrun();
        int nticks;
        do_reset();
        auto_frames = 1'b1; run = 1'b1; done_delay = 0;
        wait_tick("ovr_first", 4 * FR);
        for (int i = 0; i < FR; i++) begin
            cycle();
            vectors++;
            if (dut_vec !== exp_vec()) begin
                miscompares++;
                $display("FAIL ovr_frame cyc=%0d got=%h exp=%h", i, dut_vec, exp_vec());
            end
        end
        vectors++;
        if (overrun !== 1'b1) begin
            miscompares++;
            $display("FAIL ovr_set got=%b exp=1", overrun);
        end
        nticks = 0;
        for (int i = 0; i < 2 * FR + 4; i++) begin
            cycle();
            if (game_tick === 1'b1) nticks++;
            vectors++;
            if (dut_vec !== exp_vec()) begin
                miscompares++;
                $display("FAIL ovr_drop cyc=%0d got=%h exp=%h", i, dut_vec, exp_vec());
            end
        end
        vectors++;
        if (nticks !== 0 || overrun !== 1'b1) begin
            miscompares++;
            $display("FAIL ovr_dropped got ticks=%0d ovr=%b exp ticks=0 ovr=1", nticks, overrun);
        end
        done_cnt = 1; done_delay = 10;
        cycle();
        vectors++;
        if (busy !== 1'b0 || overrun !== 1'b1) begin
            miscompares++;
            $display("FAIL ovr_done got busy=%b ovr=%b exp busy=0 ovr=1", busy, overrun);
        end
        wait_tick("ovr_resume", 4 * FR);
    endtask

    task automatic test_simultaneous();
        do_reset();
        auto_frames = 1'b1; run = 1'b1; done_delay = 0;
        wait_tick("sim_first", 4 * FR);
        force_fs_done = 1'b1;
        for (int i = 0; i < 2 * FR && force_fs_done; i++) begin
            cycle();
            vectors++;
            if (dut_vec !== exp_vec()) begin
                miscompares++;
                $display("FAIL sim_wait got=%h exp=%h", dut_vec, exp_vec());
            end
        end
        vectors++;
        if (force_fs_done || {busy, overrun, game_tick} !== 3'b000) begin
            miscompares++;
            $display("FAIL sim_both got busy=%b ovr=%b tick=%b exp 0 0 0", busy, overrun, game_tick);
        end
        done_delay = 10;
        for (int i = 0; i < FR; i++) begin
            cycle();
            vectors++;
            if (dut_vec !== exp_vec()) begin
                miscompares++;
                $display("FAIL sim_frame got=%h exp=%h", dut_vec, exp_vec());
            end
        end
        run = 1'b0;
        repeat (5) cycle();
        run = 1'b1;
        fs_count = 0;
        wait_tick("run_restart", 5 * FR);
        vectors++;
        if (fs_count !== TICK) begin
            miscompares++;
            $display("FAIL run_restart_frames got=%0d exp=%0d", fs_count, TICK);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        auto_frames = 1'b1; run = 1'b1; done_delay = 0;
        wait_tick("rstmid", 4 * FR);
        for (int i = 0; i < 2 * FR && phase != 2; i++) cycle();
        wr_valid = 1'b1; wr_addr = 10'h2AA; wr_data = 3'd5;
        cycle();
        wr_valid = 1'b0;
        cycle();
        vectors++;
        if (busy !== 1'b1 || wr_ready !== 1'b0 || dut_vec !== exp_vec()) begin
            miscompares++;
            $display("FAIL rstmid_setup got busy=%b rdy=%b vec=%h exp busy=1 rdy=0 vec=%h",
                     busy, wr_ready, dut_vec, exp_vec());
        end
        reset = 1'b0;
        #2;
        vectors++;
        if (dut_vec !== RST_VEC) begin
            miscompares++;
            $display("FAIL rstmid_async got=%h exp=%h", dut_vec, RST_VEC);
        end
        repeat (2) @(posedge clock_25);
        model_clear();
        display_area = 1'b0; frame_tik = 1'b0; run = 1'b0; update_done = 1'b0;
        @(negedge clock_25);
        reset = 1'b1;
        for (int i = 0; i < 20; i++) begin
            rd_addr = AW'($urandom);
            cycle();
            vectors++;
            if (mem_we !== 1'b0 || dut_vec !== exp_vec()) begin
                miscompares++;
                $display("FAIL rstmid_nocommit cyc=%0d got=%h exp=%h", i, dut_vec, exp_vec());
            end
        end
    endtask

    task automatic test_random();
        do_reset();
        auto_frames = 1'b1; run = 1'b1; done_delay = 12;
        for (int i = 0; i < 2000; i++) begin
            rd_addr  = AW'($urandom);
            wr_valid = ($urandom_range(0, 2) != 0);
            wr_addr  = AW'($urandom);
            wr_data  = DW'($urandom);
            if ($urandom_range(0, 199) == 0) run = ~run;
            inject_done = ($urandom_range(0, 63) == 0);
            done_delay  = $urandom_range(1, 60);
            cycle();
            vectors++;
            if (dut_vec !== exp_vec()) begin
                miscompares++;
                $display("FAIL random cyc=%0d got=%h exp=%h", i, dut_vec, exp_vec());
            end
        end
        inject_done = 1'b0;
        wr_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_write_active();
        test_back_to_back();
        test_tick();
        test_overrun();
        test_simultaneous();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/vga_frame_scheduler.md
Name: vga_frame_scheduler

Overview:
Sequences access to the shared single-port tile memory between the VGA renderer (read) and the snake game logic (write), using display_area and frame_tik from the VGA timing generator. During active video the renderer owns the port. Game writes are buffered and committed only during blanking. The block also derives the game-step tick from frame starts and tracks the update handshake with the game logic, flagging overruns.

Parameters:
ADDR_W, 10, tile memory address width
DATA_W, 3, tile memory data width
TICK_FRAMES, 8, frames per game step (range 1..255)

Ports:
clock_25  in  1  pixel clock
reset  in  1  asynchronous, active-low reset
display_area  in  1  high during active video
frame_tik  in  1  high during vertical sync
rd_addr  in  ADDR_W  renderer read address
run  in  1  game running; enables frame counting
wr_valid  in  1  game write request
wr_addr  in  ADDR_W  game write address
wr_data  in  DATA_W  game write data
wr_ready  out  1  write slot free
update_done  in  1  1-cycle pulse: game step finished
mem_addr  out  ADDR_W  registered memory address
mem_we  out  1  registered memory write enable
mem_wdata  out  DATA_W  registered memory write data
game_tick  out  1  1-cycle pulse: start game step
busy  out  1  high while a game step is outstanding
overrun  out  1  sticky: step not finished within one frame

Behaviour:
- Reset is asynchronous and active-low, on clock_25. Reset state: mem_addr=0, mem_we=0, mem_wdata=0, game_tick=0, busy=0, overrun=0, wr_ready=1. The pending buffer is empty, the frame counter is 0, the FSM is in S_IDLE, and the frame_tik edge register is 0. Reset asserted mid-operation discards a pending write without committing it.
- Write buffer: one entry. wr_ready = ~pend_full, driven from a register with no combinational path from wr_valid. A write is accepted when wr_valid && wr_ready; wr_addr and wr_data are captured and pend_full is set.
- Port mux, registered, 1-cycle latency. Each cycle:
  - If display_area=1: mem_addr<=rd_addr, mem_we<=0.
  - Else if pend_full: mem_addr<=pend_addr, mem_wdata<=pend_data, mem_we<=1, pend_full<=0.
  - Else: mem_addr<=rd_addr, mem_we<=0.
- mem_wdata holds its last value when mem_we=0.
- Commit latency: earliest is 2 cycles after acceptance (accept edge, then commit edge). The sustained rate is 1 write per 2 cycles. No write is ever issued in a cycle sampled with display_area=1.
- Frame start: frame_start = frame_tik && ~frame_tik_q, a 1-cycle pulse on the rising edge of frame_tik.
- Frame counter, 8 bits:
  - Cleared to 0 while run=0.
  - On frame_start with run=1: increments, and wraps to 0 when it equals TICK_FRAMES-1. That wrap marks the tick as due.
- FSM S_IDLE:
  - When the tick is due: game_tick=1 for that cycle, busy<=1, go to S_UPDATE.
  - update_done in S_IDLE is ignored.
- FSM S_UPDATE:
  - update_done without frame_start: go to S_IDLE, busy<=0.
  - frame_start without update_done: overrun<=1 (sticky until reset), stay in S_UPDATE, no game_tick. The frame counter still advances, so a tick due in that frame is dropped.
  - update_done together with frame_start in the same cycle: go to S_IDLE, no overrun, no game_tick in that cycle.
- game_tick is registered and is never high for 2 consecutive cycles.

Optional Feature:
- Macro: VGA_SCHED_STATS_EN.
- When defined, adds output wr_count (8 bits), reset to 0. An internal counter increments on each committed write (mem_we=1) and saturates at 255. On frame_start, wr_count latches the internal counter and the internal counter restarts at 0; if a commit coincides with frame_start, it counts as 1.
- When undefined, the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Write during active video: display_area=1, write addr=0x05 data=3 accepted. Response: wr_ready=0, mem_we stays 0 while display_area=1, and mem_we=1 with mem_addr=0x05, mem_wdata=3 one cycle after display_area first samples 0. wr_ready then returns to 1.
- Back-to-back writes during blanking: display_area=0, wr_valid held with 4 writes. Response: 4 commits at 1 per 2 cycles, in order, with mem_addr=rd_addr on non-commit cycles.
- Tick generation: TICK_FRAMES=3, run=1, update_done returned 10 cycles after each tick. Response: game_tick on the 3rd, 6th and 9th frame starts; busy high for exactly tick to done+1; overrun=0.
- Overrun: update_done withheld across one frame_start after a tick. Response: overrun=1 and stays 1; no game_tick on the next due frame; after update_done, busy=0 and ticks resume.
- Simultaneous update_done and frame_start in S_UPDATE. Response: S_IDLE, overrun=0, game_tick=0 in that cycle. Also: run=0 clears the counter, so the first tick comes TICK_FRAMES frames after run is reasserted.
- Reset mid-operation: reset asserted with a pending write and busy=1. Response: all outputs go to their reset values immediately, and the pending write is never committed after release.
